chirp_sample_buffer: RTL and testbench
======================================

Name: chirp_sample_buffer

Overview:
- Sits directly downstream of the ADC down-sampler.
- Collects one chirp's worth of decimated 13-bit ADC samples into a ping-pong buffer and converts offset-binary samples to two's complement.
- Streams each completed chirp to the range-FFT stage over a valid/ready interface.
- Two banks let chirp N+1 fill while chirp N drains.

Parameters:
- DATA_WIDTH, 13, input sample width (offset binary).
- OUT_WIDTH, 16, output sample width (two's complement, sign-extended); must be >= DATA_WIDTH.
- DEPTH_LOG2, 8, log2 of samples per bank (256).

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- chirp_start_i  in  1  one-cycle pulse marking the start of a chirp.
- sample_num_i  in  DEPTH_LOG2+1  samples per chirp; sampled at chirp_start_i; 0 means 2^DEPTH_LOG2; values above 2^DEPTH_LOG2 are clamped to 2^DEPTH_LOG2.
- sampled_data_valid_i  in  1  sample strobe from the down-sampler.
- sampled_data_i  in  DATA_WIDTH  sample, offset binary.
- out_valid_o  out  1  output sample valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  OUT_WIDTH  two's-complement sample.
- out_index_o  out  DEPTH_LOG2  sample index within the chirp.
- out_last_o  out  1  high with the final sample of a chirp.
- chirp_drop_o  out  1  one-cycle pulse: chirp_start_i rejected because no bank was free.
- chirp_abort_o  out  1  one-cycle pulse: chirp_start_i arrived mid-fill, so the partial chirp is discarded.

Behaviour:
- Reset:
  - Both banks empty; write FSM W_IDLE; read FSM R_IDLE.
  - All outputs 0. Any in-flight chirp is lost, with no pulse.
- Write FSM, states W_IDLE and W_FILL:
  - W_IDLE, chirp_start_i, a bank free:
    - Select the free bank; bank 0 if both are free, otherwise the one not full/draining.
    - Latch the sample count (the value of sample_num_i after the 0/clamp rules); wr_cnt=0; go to W_FILL.
  - W_IDLE, chirp_start_i, no bank free: pulse chirp_drop_o next cycle; stay in W_IDLE.
  - W_IDLE: sampled_data_valid_i is ignored.
  - W_FILL, each sampled_data_valid_i: write the sample at wr_cnt and increment wr_cnt.
  - W_FILL, write with wr_cnt == count-1: mark the bank full at that clock edge; go to W_IDLE.
  - W_FILL, chirp_start_i (takes priority over a same-cycle sample):
    - Pulse chirp_abort_o; the partial data is never marked full.
    - Re-latch sample_num_i, reset wr_cnt=0, refill the same bank; stay in W_FILL.
  - chirp_start_i in the same cycle as the completing write: the completion stands. Then apply the W_IDLE rules in the next cycle only if chirp_start_i is still high there; otherwise that start is ignored (one-cycle pulse, counted as a drop, chirp_drop_o pulses).
- Read FSM, states R_IDLE, R_FETCH and R_STREAM:
  - R_IDLE, a full bank exists: select the oldest full bank, rd_cnt=0, go to R_FETCH.
  - R_FETCH: one cycle of RAM read latency.
  - R_STREAM: out_valid_o=1.
  - Timing: out_valid_o rises exactly 2 cycles after the edge at which the bank became full (read side idle). Fixed 2-cycle bubble between consecutive chirps.
  - While out_valid_o && !out_ready_i, out_data_o, out_index_o and out_last_o are held stable.
  - Each handshake advances rd_cnt with no bubble, giving 1 sample/cycle under continuous ready.
  - Handshake with out_last_o: the bank is freed at that edge; go to R_IDLE.
  - A bank freed at the same edge as the other bank completes its fill: both updates apply.
- Arithmetic:
  - out_data_o = sign_extend(sampled_data_i XOR 2^(DATA_WIDTH-1)).
  - Examples: 0x1000 → 0; 0x0000 → -4096 (0xF000); 0x1FFF → +4095 (0x0FFF).
- Ordering:
  - Chirps are output in completion order.
  - Samples within a chirp are output in write order, index 0..count-1.
  - out_last_o is high only when out_index_o == count-1.

Test Plan:
- Reset then sample_num_i=4, chirp_start, samples 0x1000,0x0000,0x1FFF,0x1001 with ready=1 → 2 cycles after the 4th write, 4 consecutive outputs 0x0000,0xF000,0x0FFF,0x0001, indices 0..3, last on index 3.
- Ready toggled 1/0 every cycle during a 16-sample chirp → outputs held while stalled; all 16 samples delivered exactly once, in order.
- ready=0, three chirps of 8 started back to back → first two fill both banks; third gives chirp_drop_o pulse. Releasing ready drains chirp1 then chirp2 with a 2-cycle gap.
- chirp_start after 3 of 8 samples, then 8 samples → chirp_abort_o pulse; output is only the 8 new samples.
- sample_num_i=0 → 256 samples collected; out_last_o at index 255.
- rst asserted mid-fill and mid-drain → next cycle all outputs 0 and banks empty; a following 4-sample chirp outputs normally.

Source files
------------

// File: rtl/chirp_sample_buffer.sv
// Ping-pong chirp sample buffer. It collects one chirp of decimated offset-binary ADC samples
// into a free bank. Completed chirps are streamed, oldest first, as sign-extended two's
// complement over a valid/ready interface. One bank can fill while the other drains.
module chirp_sample_buffer #(
  parameter int unsigned DATA_WIDTH = 13,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chirp_start_i,
  input  logic [DEPTH_LOG2:0]   sample_num_i,
  input  logic                  sampled_data_valid_i,
  input  logic [DATA_WIDTH-1:0] sampled_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic [DEPTH_LOG2-1:0] out_index_o,
  output logic                  out_last_o,
  output logic                  chirp_drop_o,
  output logic                  chirp_abort_o
);

  localparam int unsigned             Depth    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     MaxNum   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]     NumOne   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0]   IdxOne   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]   SignFlip = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {WIdle, WFill} wr_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RStream} rd_state_e;

  // Sample storage, one array per bank
  logic [DATA_WIDTH-1:0] r_mem0 [Depth];
  logic [DATA_WIDTH-1:0] r_mem1 [Depth];

  // Bank bookkeeping
  logic [1:0]            r_full;        // bank holds a complete chirp (filled or draining)
  logic                  r_oldest;      // earlier-completed bank when both are full
  logic [DEPTH_LOG2:0]   r_bank_num [2];

  // Write side
  wr_state_e             r_wr_state;
  wr_state_e             w_wr_state_next;
  logic                  r_wr_bank;
  logic [DEPTH_LOG2-1:0] r_wr_cnt;
  logic                  r_drop;
  logic                  r_abort;

  logic [DEPTH_LOG2:0]   w_num;
  logic                  w_any_free;
  logic                  w_free_sel;
  logic                  w_wr_last;
  logic                  w_start_ok;
  logic                  w_wr_en;
  logic                  w_complete;
  logic                  w_abort;
  logic                  w_drop;
  logic                  w_other_stays;

  // Read side
  rd_state_e             r_rd_state;
  rd_state_e             w_rd_state_next;
  logic                  r_rd_bank;
  logic [DEPTH_LOG2-1:0] r_rd_cnt;
  logic [OUT_WIDTH-1:0]  r_out_data;
  logic [DEPTH_LOG2-1:0] r_out_index;
  logic                  r_out_last;

  logic                  w_rd_any;
  logic                  w_rd_sel;
  logic                  w_load;
  logic                  w_free;
  logic                  w_rd_last;
  logic [DATA_WIDTH-1:0] w_rd_raw;
  logic [DATA_WIDTH-1:0] w_rd_flip;
  logic [OUT_WIDTH-1:0]  w_rd_conv;

  // ---------------------------------------------------------------------------------------
  // Write side decode
  // ---------------------------------------------------------------------------------------

  // A zero count means a full bank; oversize counts saturate to a full bank
  assign w_num      = ((sample_num_i == '0) || (sample_num_i > MaxNum)) ? MaxNum : sample_num_i;
  assign w_any_free = ~(r_full[0] & r_full[1]);
  // Bank 0 wins when both are free
  assign w_free_sel = r_full[0];
  assign w_wr_last  = ({1'b0, r_wr_cnt} == (r_bank_num[r_wr_bank] - NumOne));
  assign w_complete = w_wr_en & w_wr_last;

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= WIdle;
    end else begin
      r_wr_state <= w_wr_state_next;
    end
  end

  // Write FSM next state; a completing write beats a same-cycle chirp start
  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      WIdle: begin
        if (chirp_start_i && w_any_free) begin
          w_wr_state_next = WFill;
        end
      end
      WFill: begin
        if (sampled_data_valid_i && w_wr_last) begin
          w_wr_state_next = WIdle;
        end
      end
      default: w_wr_state_next = WIdle;
    endcase
  end

  // Write FSM outputs: accept/abort/drop decisions and the RAM write strobe
  always_comb begin
    w_start_ok = 1'b0;
    w_wr_en    = 1'b0;
    w_abort    = 1'b0;
    w_drop     = 1'b0;
    case (r_wr_state)
      WIdle: begin
        w_start_ok = chirp_start_i & w_any_free;
        w_drop     = chirp_start_i & ~w_any_free;
      end
      WFill: begin
        w_wr_en = sampled_data_valid_i & (~chirp_start_i | w_wr_last);
        w_abort = chirp_start_i & ~(sampled_data_valid_i & w_wr_last);
        // Start coinciding with the completing write is lost, reported as a drop
        w_drop  = chirp_start_i & sampled_data_valid_i & w_wr_last;
      end
      default: begin
        w_start_ok = 1'b0;
      end
    endcase
  end

  // Write datapath: bank choice, sample count latch, write pointer, status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank     <= 1'b0;
      r_wr_cnt      <= '0;
      r_bank_num[0] <= MaxNum;
      r_bank_num[1] <= MaxNum;
      r_drop        <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_drop  <= w_drop;
      r_abort <= w_abort;
      if (w_start_ok) begin
        r_wr_bank              <= w_free_sel;
        r_bank_num[w_free_sel] <= w_num;
        r_wr_cnt               <= '0;
      end else if (w_abort) begin
        // Refill the same bank from scratch with the new count
        r_bank_num[r_wr_bank] <= w_num;
        r_wr_cnt              <= '0;
      end else if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + IdxOne;
      end
    end
  end

  // Sample RAM write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_wr_bank) begin
        r_mem1[r_wr_cnt] <= sampled_data_i;
      end else begin
        r_mem0[r_wr_cnt] <= sampled_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Bank status
  // ---------------------------------------------------------------------------------------

  // The freed bank is always the read bank, i.e. the one not being written
  assign w_other_stays = r_full[~r_wr_bank] & ~w_free;

  // Full flags and completion order; fill and free of different banks may share an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= 2'b00;
      r_oldest <= 1'b0;
    end else begin
      if (w_complete) begin
        r_full[r_wr_bank] <= 1'b1;
        if (!w_other_stays) begin
          r_oldest <= r_wr_bank;
        end
      end
      if (w_free) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------------------

  // In RIdle no bank is draining, so any full bank is a candidate
  assign w_rd_any  = r_full[0] | r_full[1];
  assign w_rd_sel  = (r_full == 2'b11) ? r_oldest : r_full[1];
  assign w_rd_last = ({1'b0, r_rd_cnt} == (r_bank_num[r_rd_bank] - NumOne));
  assign w_rd_raw  = r_rd_bank ? r_mem1[r_rd_cnt] : r_mem0[r_rd_cnt];
  // Offset binary to two's complement: flip the MSB, then sign-extend
  assign w_rd_flip = w_rd_raw ^ SignFlip;
  assign w_rd_conv = OUT_WIDTH'($signed(w_rd_flip));

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= RIdle;
    end else begin
      r_rd_state <= w_rd_state_next;
    end
  end

  // Read FSM next state
  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      RIdle: begin
        if (w_rd_any) begin
          w_rd_state_next = RFetch;
        end
      end
      RFetch: begin
        w_rd_state_next = RStream;
      end
      RStream: begin
        if (out_ready_i && r_out_last) begin
          w_rd_state_next = RIdle;
        end
      end
      default: w_rd_state_next = RIdle;
    endcase
  end

  // Read FSM outputs: valid, output-register load and bank release
  always_comb begin
    out_valid_o = 1'b0;
    w_load      = 1'b0;
    w_free      = 1'b0;
    case (r_rd_state)
      RFetch: begin
        w_load = 1'b1;
      end
      RStream: begin
        out_valid_o = 1'b1;
        w_load      = out_ready_i & ~r_out_last;
        w_free      = out_ready_i & r_out_last;
      end
      default: begin
        out_valid_o = 1'b0;
      end
    endcase
  end

  // Read datapath: bank select and registered RAM read into the held output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else if ((r_rd_state == RIdle) && w_rd_any) begin
      r_rd_bank <= w_rd_sel;
      r_rd_cnt  <= '0;
    end else if (w_load) begin
      r_out_data  <= w_rd_conv;
      r_out_index <= r_rd_cnt;
      r_out_last  <= w_rd_last;
      r_rd_cnt    <= r_rd_cnt + IdxOne;
    end
  end

  assign out_data_o    = r_out_data;
  assign out_index_o   = r_out_index;
  assign out_last_o    = r_out_last;
  assign chirp_drop_o  = r_drop;
  assign chirp_abort_o = r_abort;

endmodule

// File: tb/tb_chirp_sample_buffer.sv
// Scoreboard bench for chirp_sample_buffer: expected samples are queued as chirps are written
// and checked as they are handshaken out; stall stability and pulse counts are also checked.
module tb_chirp_sample_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        chirp_start_i;
  logic [8:0]  sample_num_i;
  logic        sampled_data_valid_i;
  logic [12:0] sampled_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic [7:0]  out_index_o;
  logic        out_last_o;
  logic        chirp_drop_o;
  logic        chirp_abort_o;

  chirp_sample_buffer #(
    .DATA_WIDTH (13),
    .OUT_WIDTH  (16),
    .DEPTH_LOG2 (8)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .chirp_start_i        (chirp_start_i),
    .sample_num_i         (sample_num_i),
    .sampled_data_valid_i (sampled_data_valid_i),
    .sampled_data_i       (sampled_data_i),
    .out_valid_o          (out_valid_o),
    .out_ready_i          (out_ready_i),
    .out_data_o           (out_data_o),
    .out_index_o          (out_index_o),
    .out_last_o           (out_last_o),
    .chirp_drop_o         (chirp_drop_o),
    .chirp_abort_o        (chirp_abort_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_drop = 0;
  int   n_abort = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [12:0] d, input int idx, input int cnt);
    exp_t e;
    e.data = 16'(int'(d) - 4096);
    e.idx  = 8'(idx);
    e.last = (idx == cnt - 1);
    exp_q.push_back(e);
  endtask

  task automatic start_chirp(input logic [8:0] num);
    sample_num_i  = num;
    chirp_start_i = 1'b1;
    tick();
    chirp_start_i = 1'b0;
  endtask

  task automatic send(input logic [12:0] d);
    sampled_data_valid_i = 1'b1;
    sampled_data_i       = d;
    tick();
    sampled_data_valid_i = 1'b0;
  endtask

  // Random chirp: cnt samples written, pushed to the scoreboard when push is set
  task automatic send_chirp(input logic [8:0] num, input int cnt, input bit push);
    logic [12:0] d;
    start_chirp(num);
    for (int i = 0; i < cnt; i++) begin
      d = 13'($urandom_range(0, 8191));
      if (push) push_exp(d, i, cnt);
      send(d);
    end
  endtask

  task automatic drain(input int max_cyc, input bit toggle);
    int n;
    n = 0;
    out_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
      if (toggle) out_ready_i = ~out_ready_i;
    end
    check("drain_done", exp_q.size(), 0);
    out_ready_i = 1'b1;
    repeat (3) tick();
  endtask

  // Output monitor: scoreboard compare on handshake, hold check while stalled
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [7:0]  prev_idx;
  logic        prev_last;

  always @(negedge clk) begin
    exp_t e;
    if (chirp_drop_o) n_drop++;
    if (chirp_abort_o) n_abort++;
    if (!rst && out_valid_o) begin
      if (prev_stall) begin
        check("hold_data", out_data_o, prev_data);
        check("hold_idx", out_index_o, prev_idx);
        check("hold_last", out_last_o, prev_last);
      end
      if (out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data_o, e.data);
          check("out_idx", out_index_o, e.idx);
          check("out_last", out_last_o, e.last);
        end
      end
      prev_stall = !out_ready_i;
      prev_data  = out_data_o;
      prev_idx   = out_index_o;
      prev_last  = out_last_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] t1 [4];
    logic        vhist [24];
    int          run1;
    int          gap;
    int          run2;
    int          k;

    rst                  = 1'b1;
    chirp_start_i        = 1'b0;
    sample_num_i         = '0;
    sampled_data_valid_i = 1'b0;
    sampled_data_i       = '0;
    out_ready_i          = 1'b1;
    repeat (3) tick();
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_idx", out_index_o, 0);
    check("rst_last", out_last_o, 0);
    check("rst_drop", chirp_drop_o, 0);
    check("rst_abort", chirp_abort_o, 0);
    rst = 1'b0;
    tick();

    // 1: basic conversion and 2-cycle latency
    t1[0] = 13'h1000; t1[1] = 13'h0000; t1[2] = 13'h1FFF; t1[3] = 13'h1001;
    start_chirp(9'd4);
    for (int i = 0; i < 4; i++) begin
      push_exp(t1[i], i, 4);
      send(t1[i]);
    end
    check("t1_lat0", out_valid_o, 0);
    tick();
    check("t1_lat1", out_valid_o, 0);
    tick();
    check("t1_lat2", out_valid_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_burst", out_valid_o, 1);
    end
    tick();
    check("t1_end", out_valid_o, 0);
    check("t1_q", exp_q.size(), 0);
    repeat (2) tick();

    // 2: 16 samples drained with ready toggling every cycle
    send_chirp(9'd16, 16, 1'b1);
    drain(200, 1'b1);

    // 3: ready low, three chirps back to back; third is dropped
    out_ready_i = 1'b0;
    send_chirp(9'd8, 8, 1'b1);
    send_chirp(9'd8, 8, 1'b1);
    send_chirp(9'd8, 8, 1'b0);
    tick();
    check("t3_drop", n_drop, 1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      vhist[i] = out_valid_o;
      tick();
    end
    run1 = 0; gap = 0; run2 = 0; k = 0;
    while (k < 24 && vhist[k]) begin run1++; k++; end
    while (k < 24 && !vhist[k]) begin gap++; k++; end
    while (k < 24 && vhist[k]) begin run2++; k++; end
    check("t3_run1", run1, 8);
    check("t3_gap", gap, 2);
    check("t3_run2", run2, 8);
    drain(50, 1'b0);

    // 4: abort after 3 of 8, only the refill comes out
    send_chirp(9'd8, 3, 1'b0);
    send_chirp(9'd8, 8, 1'b1);
    tick();
    check("t4_abort", n_abort, 1);
    drain(100, 1'b0);

    // 4b: start on the completing write is dropped, completed chirp still streams
    start_chirp(9'd2);
    push_exp(13'h0123, 0, 2);
    send(13'h0123);
    push_exp(13'h1F00, 1, 2);
    chirp_start_i = 1'b1;
    send(13'h1F00);
    chirp_start_i = 1'b0;
    tick();
    check("t4b_drop", n_drop, 2);
    check("t4b_abort", n_abort, 1);
    drain(50, 1'b0);

    // 5: count 0 means 256; oversize count clamps to 256
    send_chirp(9'd0, 256, 1'b1);
    drain(600, 1'b0);
    send_chirp(9'd300, 256, 1'b1);
    drain(600, 1'b0);

    // 6: reset mid-drain and mid-fill, then a normal chirp
    out_ready_i = 1'b0;
    send_chirp(9'd8, 8, 1'b0);
    send_chirp(9'd8, 3, 1'b0);
    check("t6_pre_valid", out_valid_o, 1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("t6_valid", out_valid_o, 0);
    check("t6_data", out_data_o, 0);
    check("t6_idx", out_index_o, 0);
    check("t6_last", out_last_o, 0);
    check("t6_drop", chirp_drop_o, 0);
    check("t6_abort", chirp_abort_o, 0);
    rst = 1'b0;
    out_ready_i = 1'b1;
    repeat (4) tick();
    check("t6_idle", out_valid_o, 0);
    send_chirp(9'd4, 4, 1'b1);
    drain(50, 1'b0);
    check("t6_drop_total", n_drop, 2);
    check("t6_abort_total", n_abort, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
